// File: rtl/game_board_ctrl.sv
// rtl/game_board_ctrl.sv - two-player battleship board store, placement/shot referee and turn tracker
// Optional feature macro: BOARD_ADJ_CHECK_EN (reject placements touching an existing ship).
module game_board_ctrl #(
  parameter int GRID_W  = 9,
  parameter int GRID_H  = 9,
  parameter int SHIPS   = 4,
  parameter int COORD_W = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         restart,
  input  logic                         cmd_valid,
  output logic                         cmd_ready,
  input  logic [COORD_W-1:0]           cmd_x,
  input  logic [COORD_W-1:0]           cmd_y,
  output logic                         resp_valid,
  output logic [2:0]                   resp_code,
  input  logic                         rd_player,
  input  logic [COORD_W-1:0]           rd_x,
  input  logic [COORD_W-1:0]           rd_y,
  output logic [1:0]                   rd_code,
  output logic [1:0]                   phase,
  output logic                         turn,
  output logic [$clog2(SHIPS+1)-1:0]   ships_left_host,
  output logic [$clog2(SHIPS+1)-1:0]   ships_left_guest,
  output logic                         winner
);

  localparam int CW = $clog2(SHIPS + 1);
  localparam int XW = (GRID_W > 1) ? $clog2(GRID_W) : 1;
  localparam int YW = (GRID_H > 1) ? $clog2(GRID_H) : 1;

  localparam logic [COORD_W:0] W_LIM   = (COORD_W + 1)'(GRID_W);
  localparam logic [COORD_W:0] H_LIM   = (COORD_W + 1)'(GRID_H);
  localparam logic [CW-1:0]    SHIPS_M1 = CW'(SHIPS - 1);
  localparam logic [CW-1:0]    CNT_ONE  = CW'(1);

  localparam logic [1:0] CELL_EMPTY = 2'b00;
  localparam logic [1:0] CELL_SHIP  = 2'b01;
  localparam logic [1:0] CELL_HIT   = 2'b10;
  localparam logic [1:0] CELL_MISS  = 2'b11;

  localparam logic [2:0] RESP_PLACED  = 3'b000;
  localparam logic [2:0] RESP_HIT     = 3'b001;
  localparam logic [2:0] RESP_MISS    = 3'b010;
  localparam logic [2:0] RESP_OOB     = 3'b011;
  localparam logic [2:0] RESP_REPEAT  = 3'b100;
  localparam logic [2:0] RESP_ADJ     = 3'b101;

  typedef enum logic [1:0] {
    PH_PLACE_H = 2'd0,
    PH_PLACE_G = 2'd1,
    PH_BATTLE  = 2'd2,
    PH_OVER    = 2'd3
  } phase_t;

  // cells[player][row][column]; player 0 is the host board
  logic [1:0] cells [0:1][0:GRID_H-1][0:GRID_W-1];

  phase_t            phase_q;
  logic              busy;
  logic              accept;
  logic              tgt;
  logic [XW-1:0]     xi;
  logic [YW-1:0]     yi;
  logic              oob;
  logic              placing;
  logic [1:0]        tgt_cell;
  logic              adj;
  logic [2:0]        code;
  logic              wr_en;
  logic [1:0]        wr_val;
  logic              rd_oob;
  logic [1:0]        rd_cell;

  assign phase     = phase_q;
  assign cmd_ready = ~busy & (phase_q != PH_OVER);
  assign accept    = cmd_valid & cmd_ready & ~restart;

`ifdef BOARD_ADJ_CHECK_EN
  int nx;
  int ny;

  // 8-neighbourhood scan of the target board, clipped at the edges; the centre is left to the repeat check
  always_comb begin
    adj = 1'b0;
    nx  = 0;
    ny  = 0;
    if (placing && !oob) begin
      for (int dy = -1; dy <= 1; dy++) begin
        for (int dx = -1; dx <= 1; dx++) begin
          nx = int'(cmd_x) + dx;
          ny = int'(cmd_y) + dy;
          if (!(dx == 0 && dy == 0) && nx >= 0 && nx < GRID_W && ny >= 0 && ny < GRID_H) begin
            if (cells[tgt][ny[YW-1:0]][nx[XW-1:0]] == CELL_SHIP) begin
              adj = 1'b1;
            end
          end
        end
      end
    end
  end
`else
  assign adj = 1'b0;
`endif

  always_comb begin
    xi       = cmd_x[XW-1:0];
    yi       = cmd_y[YW-1:0];
    oob      = ({1'b0, cmd_x} >= W_LIM) || ({1'b0, cmd_y} >= H_LIM);
    placing  = (phase_q == PH_PLACE_H) || (phase_q == PH_PLACE_G);
    case (phase_q)
      PH_PLACE_H: tgt = 1'b0;
      PH_PLACE_G: tgt = 1'b1;
      default:    tgt = ~turn;
    endcase
    tgt_cell = oob ? CELL_EMPTY : cells[tgt][yi][xi];
  end

  // Result decode: out-of-bounds first, then adjacency, then occupied/already-shot
  always_comb begin
    code   = RESP_PLACED;
    wr_en  = 1'b0;
    wr_val = CELL_EMPTY;
    if (oob) begin
      code = RESP_OOB;
    end else if (adj) begin
      code = RESP_ADJ;
    end else if (placing) begin
      if (tgt_cell == CELL_EMPTY) begin
        code   = RESP_PLACED;
        wr_en  = 1'b1;
        wr_val = CELL_SHIP;
      end else begin
        code = RESP_REPEAT;
      end
    end else begin
      case (tgt_cell)
        CELL_SHIP: begin
          code   = RESP_HIT;
          wr_en  = 1'b1;
          wr_val = CELL_HIT;
        end
        CELL_EMPTY: begin
          code   = RESP_MISS;
          wr_en  = 1'b1;
          wr_val = CELL_MISS;
        end
        default: code = RESP_REPEAT;
      endcase
    end
  end

  always_comb begin
    rd_oob  = ({1'b0, rd_x} >= W_LIM) || ({1'b0, rd_y} >= H_LIM);
    rd_cell = rd_oob ? CELL_EMPTY : cells[rd_player][rd_y[YW-1:0]][rd_x[XW-1:0]];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int p = 0; p < 2; p++)
        for (int r = 0; r < GRID_H; r++)
          for (int c = 0; c < GRID_W; c++)
            cells[p][r][c] <= CELL_EMPTY;
      phase_q          <= PH_PLACE_H;
      turn             <= 1'b0;
      ships_left_host  <= '0;
      ships_left_guest <= '0;
      winner           <= 1'b0;
      busy             <= 1'b0;
      resp_valid       <= 1'b0;
      resp_code        <= RESP_PLACED;
      rd_code          <= CELL_EMPTY;
    end else if (restart) begin
      for (int p = 0; p < 2; p++)
        for (int r = 0; r < GRID_H; r++)
          for (int c = 0; c < GRID_W; c++)
            cells[p][r][c] <= CELL_EMPTY;
      phase_q          <= PH_PLACE_H;
      turn             <= 1'b0;
      ships_left_host  <= '0;
      ships_left_guest <= '0;
      winner           <= 1'b0;
      busy             <= 1'b0;
      resp_valid       <= 1'b0;
      resp_code        <= RESP_PLACED;
      rd_code          <= CELL_EMPTY;
    end else begin
      busy       <= accept;
      resp_valid <= accept;
      rd_code    <= rd_cell;
      if (accept) begin
        resp_code <= code;
        if (wr_en) begin
          cells[tgt][yi][xi] <= wr_val;
        end
        case (phase_q)
          PH_PLACE_H: begin
            if (wr_en) begin
              ships_left_host <= ships_left_host + CNT_ONE;
              if (ships_left_host == SHIPS_M1) phase_q <= PH_PLACE_G;
            end
          end
          PH_PLACE_G: begin
            if (wr_en) begin
              ships_left_guest <= ships_left_guest + CNT_ONE;
              if (ships_left_guest == SHIPS_M1) begin
                phase_q <= PH_BATTLE;
                turn    <= 1'b0;
              end
            end
          end
          PH_BATTLE: begin
            if (wr_en && code == RESP_HIT) begin
              // Shooter keeps the turn on a hit; the last hit ends the game with the shooter as winner
              if (turn) begin
                ships_left_host <= ships_left_host - CNT_ONE;
                if (ships_left_host == CNT_ONE) begin
                  phase_q <= PH_OVER;
                  winner  <= turn;
                end
              end else begin
                ships_left_guest <= ships_left_guest - CNT_ONE;
                if (ships_left_guest == CNT_ONE) begin
                  phase_q <= PH_OVER;
                  winner  <= turn;
                end
              end
            end else if (wr_en) begin
              turn <= ~turn;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_game_board_ctrl.sv
// tb/tb_game_board_ctrl.sv - scoreboard bench for game_board_ctrl
module tb_game_board_ctrl;

`ifdef BOARD_ADJ_CHECK_EN
  localparam bit ADJ_EN = 1'b1;
`else
  localparam bit ADJ_EN = 1'b0;
`endif

  localparam logic [2:0] R_PLACED = 3'd0;
  localparam logic [2:0] R_HIT    = 3'd1;
  localparam logic [2:0] R_MISS   = 3'd2;
  localparam logic [2:0] R_OOB    = 3'd3;
  localparam logic [2:0] R_REPEAT = 3'd4;
  localparam logic [2:0] R_ADJ    = 3'd5;

  logic       clk = 1'b0;
  logic       rst;
  logic       restart;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [3:0] cmd_x;
  logic [3:0] cmd_y;
  logic       resp_valid;
  logic [2:0] resp_code;
  logic       rd_player;
  logic [3:0] rd_x;
  logic [3:0] rd_y;
  logic [1:0] rd_code;
  logic [1:0] phase;
  logic       turn;
  logic [2:0] ships_left_host;
  logic [2:0] ships_left_guest;
  logic       winner;

  int total = 0;
  int bad   = 0;
  logic [2:0] exp_q [$];

  game_board_ctrl dut (
    .clk(clk), .rst(rst), .restart(restart),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_x(cmd_x), .cmd_y(cmd_y),
    .resp_valid(resp_valid), .resp_code(resp_code),
    .rd_player(rd_player), .rd_x(rd_x), .rd_y(rd_y), .rd_code(rd_code),
    .phase(phase), .turn(turn),
    .ships_left_host(ships_left_host), .ships_left_guest(ships_left_guest),
    .winner(winner)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // Response monitor: every pulse must match the oldest outstanding expectation
  always @(negedge clk) begin
    if (!rst && resp_valid) begin
      check_eq("resp_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) check_eq("resp_code", 32'(resp_code), 32'(exp_q.pop_front()));
    end
  end

  task automatic send(input int x, input int y, input logic [2:0] code);
    int n = 0;
    while (!cmd_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!cmd_ready) begin
      check_eq("ready_timeout", 32'(cmd_ready), 32'd1);
    end else begin
      cmd_x     = 4'(x);
      cmd_y     = 4'(y);
      cmd_valid = 1'b1;
      exp_q.push_back(code);
      @(negedge clk);
      cmd_valid = 1'b0;
    end
  endtask

  task automatic rd_chk(input string tag, input logic p, input int x, input int y, input int exp);
    rd_player = p;
    rd_x      = 4'(x);
    rd_y      = 4'(y);
    @(negedge clk);
    check_eq(tag, 32'(rd_code), 32'(exp));
  endtask

  task automatic place_all();
    send(0, 0, R_PLACED); send(2, 0, R_PLACED); send(4, 0, R_PLACED); send(6, 0, R_PLACED);
    send(0, 0, R_PLACED); send(4, 4, R_PLACED); send(8, 8, R_PLACED); send(6, 6, R_PLACED);
    check_eq("replay_phase", 32'(phase), 32'd2);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; restart = 1'b0; cmd_valid = 1'b0; cmd_x = '0; cmd_y = '0;
    rd_player = 1'b0; rd_x = '0; rd_y = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_eq("rst_phase", 32'(phase), 32'd0);
    check_eq("rst_turn", 32'(turn), 32'd0);
    check_eq("rst_ships_h", 32'(ships_left_host), 32'd0);
    check_eq("rst_ships_g", 32'(ships_left_guest), 32'd0);
    check_eq("rst_winner", 32'(winner), 32'd0);
    check_eq("rst_ready", 32'(cmd_ready), 32'd1);
    check_eq("rst_resp_valid", 32'(resp_valid), 32'd0);
    check_eq("rst_resp_code", 32'(resp_code), 32'd0);
    check_eq("rst_rd_code", 32'(rd_code), 32'd0);

    // Host placement with rejects mixed in
    send(0, 0, R_PLACED);
    check_eq("ready_low_after_accept", 32'(cmd_ready), 32'd0);
    send(2, 0, R_PLACED);
    send(9, 3, R_OOB);
    send(0, 0, R_REPEAT);
    check_eq("reject_no_count", 32'(ships_left_host), 32'd2);
    send(4, 0, R_PLACED);
    check_eq("phase_before_4th", 32'(phase), 32'd0);
    send(6, 0, R_PLACED);
    check_eq("phase_after_host", 32'(phase), 32'd1);
    check_eq("ships_h_placed", 32'(ships_left_host), 32'd4);
    rd_chk("rd_host_ship", 1'b0, 2, 0, 1);

    // Guest placement, adjacency case
    send(0, 0, R_PLACED);
    send(1, 1, ADJ_EN ? R_ADJ : R_PLACED);
    send(4, 4, R_PLACED);
    send(8, 8, R_PLACED);
    if (ADJ_EN) send(6, 6, R_PLACED);
    check_eq("phase_battle", 32'(phase), 32'd2);
    check_eq("battle_turn0", 32'(turn), 32'd0);
    check_eq("ships_g_placed", 32'(ships_left_guest), 32'd4);

    // Battle
    send(3, 3, R_MISS);
    check_eq("turn_after_miss", 32'(turn), 32'd1);
    rd_chk("rd_miss_cell", 1'b1, 3, 3, 3);
    send(8, 8, R_MISS);
    check_eq("turn_back_host", 32'(turn), 32'd0);
    send(3, 3, R_REPEAT);
    check_eq("turn_kept_repeat", 32'(turn), 32'd0);
    send(9, 0, R_OOB);
    send(3, 4, R_MISS);
    send(0, 0, R_HIT);
    check_eq("ships_h_after_hit", 32'(ships_left_host), 32'd3);
    check_eq("turn_kept_hit", 32'(turn), 32'd1);
    send(2, 0, R_HIT);
    send(0, 0, R_REPEAT);
    send(4, 0, R_HIT);
    check_eq("ships_h_one", 32'(ships_left_host), 32'd1);
    send(6, 0, R_HIT);
    check_eq("over_phase", 32'(phase), 32'd3);
    check_eq("over_winner", 32'(winner), 32'd1);
    check_eq("over_ready", 32'(cmd_ready), 32'd0);
    check_eq("over_ships_h", 32'(ships_left_host), 32'd0);
    check_eq("over_ships_g", 32'(ships_left_guest), 32'd4);
    rd_chk("rd_hit_cell", 1'b0, 0, 0, 2);
    rd_chk("rd_oob", 1'b0, 15, 0, 0);

    // Commands in OVER are ignored (monitor flags any response)
    cmd_x = 4'd5; cmd_y = 4'd5; cmd_valid = 1'b1;
    repeat (3) @(negedge clk);
    cmd_valid = 1'b0;
    check_eq("over_hold", 32'(phase), 32'd3);

    // Restart from OVER
    restart = 1'b1;
    @(negedge clk);
    restart = 1'b0;
    check_eq("rs_phase", 32'(phase), 32'd0);
    check_eq("rs_ships_h", 32'(ships_left_host), 32'd0);
    check_eq("rs_ships_g", 32'(ships_left_guest), 32'd0);
    check_eq("rs_winner", 32'(winner), 32'd0);
    check_eq("rs_ready", 32'(cmd_ready), 32'd1);
    rd_chk("rs_cleared", 1'b0, 0, 0, 0);

    // Restart mid-battle with a same-cycle command
    place_all();
    send(3, 3, R_MISS);
    @(negedge clk);
    cmd_x = 4'd2; cmd_y = 4'd0; cmd_valid = 1'b1; restart = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0; restart = 1'b0;
    check_eq("rsb_resp_valid", 32'(resp_valid), 32'd0);
    check_eq("rsb_phase", 32'(phase), 32'd0);
    check_eq("rsb_ships_h", 32'(ships_left_host), 32'd0);
    rd_chk("rsb_cleared", 1'b1, 3, 3, 0);
    rd_chk("rsb_host_clear", 1'b0, 2, 0, 0);

    // Async reset just after an accept discards the pending response
    place_all();
    @(negedge clk);
    cmd_x = 4'd3; cmd_y = 4'd3; cmd_valid = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b1;
    cmd_valid = 1'b0;
    @(negedge clk);
    check_eq("rstb_resp_valid", 32'(resp_valid), 32'd0);
    check_eq("rstb_phase", 32'(phase), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check_eq("rstb_resp_valid2", 32'(resp_valid), 32'd0);
    rd_chk("rstb_cleared", 1'b1, 3, 3, 0);
    rd_chk("rstb_guest_clear", 1'b1, 4, 4, 0);

    check_eq("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
